// File: rtl/sync_fifo_stream_reader_pkg.sv
// Shared constants for the FIFO stream reader and its local buffer.
// Buffer depth is always read latency + 2: enough credit to cover the full read pipeline.
package sync_fifo_stream_reader_pkg;

   localparam int MAX_READ_LATENCY = 2;
   localparam int STATS_WIDTH      = 32;

   function automatic int buf_depth(input int latency);
      return latency + 2;
   endfunction

endpackage

// File: rtl/sync_fifo_stream_reader_if.sv
// FIFO read port plus outgoing valid/ready stream, bundled for the reader.
// master = the reader itself, slave = the FIFO/consumer side.
interface sync_fifo_stream_reader_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  o_fifo_rd_en;
   logic [DATA_WIDTH-1:0] i_fifo_rd_data;
   logic                  i_fifo_empty;
   logic                  o_m_valid;
   logic                  i_m_ready;
   logic [DATA_WIDTH-1:0] o_m_data;

   modport master (
      output o_fifo_rd_en,
      input  i_fifo_rd_data,
      input  i_fifo_empty,
      output o_m_valid,
      input  i_m_ready,
      output o_m_data
   );

   modport slave (
      input  o_fifo_rd_en,
      output i_fifo_rd_data,
      output i_fifo_empty,
      input  o_m_valid,
      output i_m_ready,
      input  o_m_data
   );
endinterface

// File: rtl/sync_fifo_stream_reader_buf.sv
// Small circular skid buffer for returning FIFO reads: push at the pipeline tail,
// pop on stream acceptance, flush empties it in one edge. Head is a plain registered-array read.
module sync_fifo_stream_reader_buf
   import sync_fifo_stream_reader_pkg::*;
#(
   parameter  int DATA_WIDTH = 8,
   parameter  int DEPTH      = 3,
   localparam int PTR_W      = $clog2(DEPTH),
   localparam int OCC_W      = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [OCC_W-1:0]      occ,
   output logic [DATA_WIDTH-1:0] head_data
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [OCC_W-1:0]      occ_q, occ_d;
   logic                  do_push, do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      do_push  = push && !flush;
      do_pop   = pop && !flush && (occ_q != '0);

      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         occ_d    = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
         end
         if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
         end
         case ({do_push, do_pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
      end
   end

   assign occ       = occ_q;
   assign head_data = mem_q[rd_ptr_q];

   // The reader's credit rule is what keeps this from ever firing.
   overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
      !(push && !flush && !pop && (occ_q == OCC_W'(DEPTH))))
      else $error("stream reader buffer overflow");

endmodule

// File: rtl/sync_fifo_stream_reader.sv
// Read-side master for the synchronous FIFO: hides its 1- or 2-cycle read latency behind
// an in-flight tracker and a local buffer. Define SYNC_FIFO_STREAM_READER_STATS_EN for o_beat_count.
module sync_fifo_stream_reader
   import sync_fifo_stream_reader_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int READ_LATENCY = 1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           i_clr,
   sync_fifo_stream_reader_if.master      bus,
   output logic                           o_busy
`ifdef SYNC_FIFO_STREAM_READER_STATS_EN
   ,
   output logic [STATS_WIDTH-1:0]         o_beat_count
`endif
);

   localparam int BUF_DEPTH = buf_depth(READ_LATENCY);
   localparam int OCC_W     = $clog2(BUF_DEPTH + 1);
   localparam int CRD_W     = $clog2(BUF_DEPTH + MAX_READ_LATENCY + 1);

   logic [READ_LATENCY-1:0] inflight_q, inflight_d;
   logic [OCC_W-1:0]        occ;
   logic [CRD_W-1:0]        outstanding;
   logic [DATA_WIDTH-1:0]   head_data;
   logic                    rd_en, push, pop, m_valid;

   // Credit only looks at registered occupancy and pipeline, never at i_m_ready.
   // rst_n gates the enable so no read is requested while the FIFO is also held in reset.
   always_comb begin
      outstanding = CRD_W'(occ) + CRD_W'($countones(inflight_q));
      rd_en       = rst_n && !bus.i_fifo_empty && !i_clr &&
                    (outstanding < CRD_W'(BUF_DEPTH));
      inflight_d  = i_clr ? '0 : READ_LATENCY'({inflight_q, rd_en});
      push        = inflight_q[READ_LATENCY-1];
      pop         = m_valid && bus.i_m_ready;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) inflight_q <= '0;
      else        inflight_q <= inflight_d;
   end

   sync_fifo_stream_reader_buf #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (BUF_DEPTH)
   ) u_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (i_clr),
      .push      (push),
      .push_data (bus.i_fifo_rd_data),
      .pop       (pop),
      .occ       (occ),
      .head_data (head_data)
   );

   assign m_valid          = (occ != '0);
   assign bus.o_fifo_rd_en = rd_en;
   assign bus.o_m_valid    = m_valid;
   assign bus.o_m_data     = head_data;
   assign o_busy           = m_valid || (inflight_q != '0);

`ifdef SYNC_FIFO_STREAM_READER_STATS_EN
   logic [STATS_WIDTH-1:0] beat_count_q, beat_count_d;

   always_comb begin
      beat_count_d = beat_count_q;
      if (i_clr)    beat_count_d = '0;
      else if (pop) beat_count_d = beat_count_q + STATS_WIDTH'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) beat_count_q <= '0;
      else        beat_count_q <= beat_count_d;
   end

   assign o_beat_count = beat_count_q;
`endif

endmodule

// File: tb/tb_sync_fifo_stream_reader.sv
// Bench for sync_fifo_stream_reader: latency-1 and latency-2 instances share one stimulus stream,
// each fed by its own FIFO model; the stream must equal the written words in order, minus flushed ones.
`timescale 1ns/1ps
module tb_sync_fifo_stream_reader;
   import sync_fifo_stream_reader_pkg::*;

   localparam int DW   = 8;
   localparam int NL   = 2;
   localparam int LOGN = 1024;

   logic          clk = 1'b0;
   logic          rst_n, clr = 1'b0, m_ready = 1'b0, wr_en = 1'b0;
   logic [DW-1:0] wr_data = '0;

   always #5 clk = ~clk;

   logic [NL-1:0] rd_en, fifo_empty, m_valid, busy;
   logic [DW-1:0] fifo_rd_data [NL];
   logic [DW-1:0] m_data [NL];
`ifdef SYNC_FIFO_STREAM_READER_STATS_EN
   logic [STATS_WIDTH-1:0] beat_count [NL];
`endif

   for (genvar g = 0; g < NL; g++) begin : g_lane
      sync_fifo_stream_reader_if #(.DATA_WIDTH(DW)) bus ();
      assign bus.i_fifo_rd_data = fifo_rd_data[g];
      assign bus.i_fifo_empty   = fifo_empty[g];
      assign bus.i_m_ready      = m_ready;
      assign rd_en[g]           = bus.o_fifo_rd_en;
      assign m_valid[g]         = bus.o_m_valid;
      assign m_data[g]          = bus.o_m_data;

      sync_fifo_stream_reader #(.DATA_WIDTH(DW), .READ_LATENCY(g + 1)) dut (
         .clk    (clk),
         .rst_n  (rst_n),
         .i_clr  (clr),
         .bus    (bus),
         .o_busy (busy[g])
`ifdef SYNC_FIFO_STREAM_READER_STATS_EN
         ,
         .o_beat_count (beat_count[g])
`endif
      );
   end

   // Model: wlog holds every word written; frd = words pulled from the FIFO, dlv = words delivered.
   logic [DW-1:0] wlog [LOGN];
   int            wptr = 0, cyc = 0;
   int            frd [NL], dlv [NL], exp_cnt [NL], beat_n [NL];
   logic [DW-1:0] rd_s1 [NL];
   logic [DW-1:0] beat_val [NL][LOGN];
   int            beat_cyc [NL][LOGN];
   logic          hold [NL];
   logic [DW-1:0] hold_data [NL];
   logic          was_clr = 1'b0;
   int            n_cmp = 0, n_fail = 0;

   task automatic chk(input string name, input int lane, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s lane%0d: got %0h expected %0h (cycle %0d)", name, lane, act, exp, cyc);
      end
   endtask

   initial begin
      for (int l = 0; l < NL; l++) begin
         frd[l] = 0; dlv[l] = 0; exp_cnt[l] = 0; beat_n[l] = 0; hold[l] = 1'b0;
      end
   end

   always @(posedge clk or negedge rst_n) begin
      logic [DW-1:0] nxt;
      if (!rst_n) begin
         for (int l = 0; l < NL; l++) begin
            frd[l] = wptr; dlv[l] = wptr; exp_cnt[l] = 0; hold[l] = 1'b0;
            rd_s1[l] = '0;
            fifo_empty[l]   <= 1'b1;
            fifo_rd_data[l] <= '0;
         end
         was_clr = 1'b0;
      end else begin
         cyc++;
         for (int l = 0; l < NL; l++) begin
            hold[l]      = m_valid[l] && !m_ready && !clr;
            hold_data[l] = m_data[l];
            if (m_valid[l] && m_ready) begin
               beat_val[l][beat_n[l]] = m_data[l];
               beat_cyc[l][beat_n[l]] = cyc;
               beat_n[l]++;
               dlv[l]++;
               if (!clr) exp_cnt[l]++;
            end
            nxt = 8'hEE;
            if (rd_en[l]) begin
               nxt = wlog[frd[l]];
               frd[l]++;
            end
            if (l == 0) fifo_rd_data[l] <= nxt;
            else begin
               fifo_rd_data[l] <= rd_s1[l];
               rd_s1[l] = nxt;
            end
         end
         if (clr) begin
            for (int l = 0; l < NL; l++) begin
               frd[l] = wptr; dlv[l] = wptr; exp_cnt[l] = 0;
            end
         end else if (wr_en) begin
            wlog[wptr] = wr_data;
            wptr++;
         end
         for (int l = 0; l < NL; l++) fifo_empty[l] <= (frd[l] == wptr);
         was_clr = clr;
      end
   end

   always @(negedge clk) begin
      #1;
      for (int l = 0; l < NL; l++) begin
         if (!rst_n) begin
            chk("rst_valid", l, m_valid[l], 0);
            chk("rst_rd_en", l, rd_en[l], 0);
            chk("rst_busy",  l, busy[l], 0);
            chk("rst_data",  l, m_data[l], 0);
         end else begin
            chk("rd_while_empty", l, rd_en[l] && fifo_empty[l], 0);
            if (clr) chk("rd_during_clr", l, rd_en[l], 0);
            chk("credit_limit", l, (frd[l] - dlv[l]) <= (l + 3), 1);
            chk("busy", l, busy[l], frd[l] != dlv[l]);
            if (m_valid[l]) begin
               chk("valid_without_word", l, dlv[l] < frd[l], 1);
               chk("data_order", l, m_data[l], wlog[dlv[l]]);
            end
            if (hold[l]) begin
               chk("hold_valid", l, m_valid[l], 1);
               chk("hold_data",  l, m_data[l], hold_data[l]);
            end
            if (was_clr) chk("valid_after_clr", l, m_valid[l], 0);
`ifdef SYNC_FIFO_STREAM_READER_STATS_EN
            chk("beat_count", l, beat_count[l], exp_cnt[l]);
`endif
         end
      end
   end

   function automatic bit lanes_idle();
      bit r = 1'b1;
      for (int l = 0; l < NL; l++)
         if (frd[l] != wptr || dlv[l] != wptr || busy[l] || m_valid[l]) r = 1'b0;
      return r;
   endfunction

   task automatic wait_idle(input int max_cyc);
      int n = 0;
      while (!lanes_idle() && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      chk("drain_timeout", 0, lanes_idle(), 1);
   endtask

   task automatic write_word(input logic [DW-1:0] d);
      wr_en = 1'b1; wr_data = d;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      int b0 [NL];
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      for (int l = 0; l < NL; l++) chk("reset_valid", l, m_valid[l], 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Basic stream at full rate: beats 0x11..0x18, valid from edge t0+LAT+1.
      m_ready = 1'b1;
      for (int l = 0; l < NL; l++) b0[l] = beat_n[l];
      wr_en = 1'b1; wr_data = 8'h11;
      @(negedge clk);
      t0 = cyc;
      for (int k = 1; k < 8; k++) begin
         wr_data = DW'(8'h11 + k);
         @(negedge clk);
      end
      wr_en = 1'b0;
      wait_idle(50);
      for (int l = 0; l < NL; l++) begin
         chk("t1_count", l, beat_n[l] - b0[l], 8);
         for (int k = 0; k < 8; k++) begin
            chk("t1_data",  l, beat_val[l][b0[l] + k], 32'h11 + k);
            chk("t1_cycle", l, beat_cyc[l][b0[l] + k], t0 + (l + 1) + 2 + k);
         end
         chk("t1_busy_low", l, busy[l], 0);
      end

      // Backpressure with ready pattern 1,0,0,1.
      for (int l = 0; l < NL; l++) b0[l] = beat_n[l];
      for (int k = 0; k < 16; k++) begin
         wr_en = 1'b1; wr_data = DW'(8'h30 + k);
         m_ready = (k % 4 == 0) || (k % 4 == 3);
         @(negedge clk);
      end
      wr_en = 1'b0;
      for (int k = 16; k < 200 && !lanes_idle(); k++) begin
         m_ready = (k % 4 == 0) || (k % 4 == 3);
         @(negedge clk);
      end
      chk("t2_drained", 0, lanes_idle(), 1);
      for (int l = 0; l < NL; l++) begin
         chk("t2_count", l, beat_n[l] - b0[l], 16);
         for (int k = 0; k < 16; k++) chk("t2_data", l, beat_val[l][b0[l] + k], 32'h30 + k);
      end

      // Clear with a read in flight; one beat accepted in the clear cycle.
      m_ready = 1'b0;
      for (int l = 0; l < NL; l++) b0[l] = beat_n[l];
      for (int k = 0; k < 8; k++) write_word(DW'(8'h40 + k));
      repeat (8) @(negedge clk);
      m_ready = 1'b1;
      repeat (2) @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0; m_ready = 1'b0;
      repeat (3) @(negedge clk);
      for (int l = 0; l < NL; l++) begin
         chk("t3_valid_low", l, m_valid[l], 0);
         chk("t3_busy_low",  l, busy[l], 0);
      end
      m_ready = 1'b1;
      write_word(8'hA5);
      wait_idle(50);
      for (int l = 0; l < NL; l++) begin
         chk("t3_count", l, beat_n[l] - b0[l], 4);
         chk("t3_beat0", l, beat_val[l][b0[l]],     8'h40);
         chk("t3_beat1", l, beat_val[l][b0[l] + 1], 8'h41);
         chk("t3_beat2", l, beat_val[l][b0[l] + 2], 8'h42);
         chk("t3_first_after_clr", l, beat_val[l][b0[l] + 3], 8'hA5);
      end

      // Sparse writes: the FIFO keeps going empty between words.
      for (int l = 0; l < NL; l++) b0[l] = beat_n[l];
      for (int k = 0; k < 6; k++) begin
         write_word(DW'(8'h60 + k));
         repeat (2) @(negedge clk);
      end
      wait_idle(50);
      for (int l = 0; l < NL; l++) begin
         chk("t4_count", l, beat_n[l] - b0[l], 6);
         for (int k = 0; k < 6; k++) chk("t4_data", l, beat_val[l][b0[l] + k], 32'h60 + k);
      end

      // Asynchronous reset with reads outstanding.
      m_ready = 1'b0;
      for (int l = 0; l < NL; l++) b0[l] = beat_n[l];
      for (int k = 0; k < 8; k++) write_word(DW'(8'h70 + k));
      rst_n = 1'b0;
      #1;
      for (int l = 0; l < NL; l++) begin
         chk("t5_rst_valid", l, m_valid[l], 0);
         chk("t5_rst_data",  l, m_data[l], 0);
         chk("t5_rst_rd_en", l, rd_en[l], 0);
         chk("t5_rst_busy",  l, busy[l], 0);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      m_ready = 1'b1;
      repeat (10) @(negedge clk);
      for (int l = 0; l < NL; l++) chk("t5_quiet", l, beat_n[l] - b0[l], 0);
      write_word(8'h7F);
      wait_idle(50);
      for (int l = 0; l < NL; l++) begin
         chk("t5_count", l, beat_n[l] - b0[l], 1);
         chk("t5_first", l, beat_val[l][b0[l]], 8'h7F);
      end

`ifdef SYNC_FIFO_STREAM_READER_STATS_EN
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      m_ready = 1'b1;
      for (int k = 0; k < 100; k++) write_word(DW'(k));
      wait_idle(300);
      for (int l = 0; l < NL; l++) chk("stats_100", l, beat_count[l], 100);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      #1;
      for (int l = 0; l < NL; l++) chk("stats_cleared", l, beat_count[l], 0);
`endif

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/sync_fifo_stream_reader.md
Name: sync_fifo_stream_reader

Overview:
- Read-side master for the team's synchronous FIFO (with clear). Drains the FIFO's enable/data/empty read port and presents it as a valid/ready stream.
- Hides the FIFO's fixed read latency (1 or 2 cycles) using an in-flight tracker and a small local buffer.
- Sits between a FIFO instance and any stream consumer. Sustains one beat per cycle with no combinational path from o_m_ready to o_fifo_rd_en.

Parameters:
- DATA_WIDTH, 8, width of the FIFO word and stream data.
- READ_LATENCY, 1, FIFO read latency in cycles. Legal values 1 or 2; 2 matches a FIFO built with the extra output register.
- Derived constant: BUF_DEPTH = READ_LATENCY + 2 local buffer entries. Not overridable.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- i_clr  in  1  synchronous flush. The same signal drives the FIFO's clear.
- o_fifo_rd_en  out  1  read enable to the FIFO.
- i_fifo_rd_data  in  DATA_WIDTH  FIFO read data.
- i_fifo_empty  in  1  FIFO empty flag.
- o_m_valid  out  1  stream valid.
- i_m_ready  in  1  stream ready.
- o_m_data  out  DATA_WIDTH  stream data.
- o_busy  out  1  high when the buffer is non-empty or any read is in flight.

Behaviour:
- Reset (rst_n low, async):
  - Buffer empty; in-flight pipeline cleared.
  - o_fifo_rd_en=0, o_m_valid=0, o_m_data=0, o_busy=0.
- In-flight pipeline:
  - READ_LATENCY-bit shift register. Bit 0 is set on the edge where o_fifo_rd_en=1.
  - When the last bit is set, i_fifo_rd_data is captured into the buffer on that edge.
  - Latency 1: data issued at edge N is captured at edge N+1. Latency 2: captured at edge N+2.
- Credit rule (registered inputs only):
  - o_fifo_rd_en = !i_fifo_empty && !i_clr && (occ + inflight) < BUF_DEPTH.
  - occ = buffer entries; inflight = popcount of the pipeline.
  - o_fifo_rd_en must not depend on i_m_ready.
- Buffer:
  - Circular, BUF_DEPTH entries, wrap-around pointers, occupancy counter of width clog2(BUF_DEPTH+1).
  - o_m_valid = (occ != 0); o_m_data = head entry (registered array read, no bypass).
  - Pop when o_m_valid && i_m_ready. Push on pipeline tail.
  - Simultaneous push and pop leaves occ unchanged. Overflow must be impossible by construction (assertion).
- Stream rules:
  - Once o_m_valid=1, o_m_valid and o_m_data hold until accepted, unless i_clr.
  - Ordering matches FIFO order exactly.
- Throughput: with i_m_ready held high and the FIFO non-empty, one beat per cycle in steady state. First beat appears READ_LATENCY+1 cycles after i_fifo_empty falls.
- i_clr (sync, highest priority, any state):
  - On the next edge: buffer emptied, pipeline zeroed, so returning data from pre-clear reads is discarded.
  - o_fifo_rd_en=0 while i_clr=1. o_m_valid=0 from the cycle after.
  - A beat accepted in the clear cycle counts as delivered.
- Reset mid-operation: same as power-up; in-flight data is dropped.

Optional Feature:
- Macro SYNC_FIFO_STREAM_READER_STATS_EN.
- Defined:
  - Extra output port o_beat_count, width STATS_WIDTH, counting accepted beats (o_m_valid && i_m_ready).
  - Wraps modulo 2^STATS_WIDTH.
  - Reset to 0 by rst_n and by i_clr; an acceptance coinciding with i_clr is not counted.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package sync_fifo_stream_reader_pkg:
  - MAX_READ_LATENCY=2.
  - STATS_WIDTH=32.
  - Function buf_depth(latency) returning latency+2.
- One sub-module, sync_fifo_stream_reader_buf:
  - The BUF_DEPTH circular buffer with push/pop/flush and occupancy output.
  - The top level owns the credit logic and the in-flight pipeline.

Test Plan:
- Basic stream, READ_LATENCY=1: FIFO preloaded with 0x11..0x18, i_m_ready=1 → beats 0x11..0x18 in order on 8 consecutive cycles, first beat 2 cycles after empty falls; o_busy falls after the last beat.
- Backpressure, READ_LATENCY=2: 16 words, i_m_ready toggles 1,0,0,1 repeating → no loss or duplication; occ+inflight never exceeds 4; o_m_data stable whenever valid && !ready.
- Clear with reads in flight: 8 words, i_m_ready=0 until the buffer fills, assert i_clr for 1 cycle → o_m_valid=0 the next cycle; no stale word ever emitted; new word 0xA5 written afterwards is the first beat out.
- Empty toggling: FIFO receives one word every 3 cycles, i_m_ready=1 → no o_fifo_rd_en while i_fifo_empty=1; each word emitted exactly once.
- Async reset mid-stream: rst_n low for 2 cycles while 3 reads are in flight → all outputs 0 immediately; nothing emitted after release until new data arrives.
- Stats (macro defined): 100 beats accepted, then i_clr → o_beat_count reads 100, then 0 the cycle after i_clr.
